// File: rtl/pipe_pkg.sv
// Shared limits and the latency-select saturation helper for the pipe stage chain.
package pipe_pkg;

  // Supported parameter ranges for the chain
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 48;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;

  // Clamp a requested latency to the number of physical stages present
  function automatic int sat_lat(input int sel, input int depth);
    return (sel > depth) ? depth : sel;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One register stage: async reset, synchronous clear, clock-enabled load.
module pipe_stage_cell #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  // Clear has priority over enable; reset clears without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (ce) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// Delay line of DEPTH stages carrying data plus valid, with a runtime-selected tap.
// Tap 0 is the live input, tap n is the output of stage n.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [LW-1:0]    lat_sel,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             busy
);

  // Each stage word is {valid, data}; the valid bit rides alongside the data
  localparam int SW = WIDTH + 1;

  logic [SW-1:0]    stage_q [0:DEPTH];
  logic [DEPTH:1]   valid_vec;
  logic [SW-1:0]    tap_next;

  // Tap 0 is the unregistered input word
  assign stage_q[0] = {din_vld, din};

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
      // Stage gi loads from stage gi-1 on every enabled edge, regardless of valid
      pipe_stage_cell #(
        .W(SW)
      ) u_cell (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .clr (flush),
        .d   (stage_q[gi-1]),
        .q   (stage_q[gi])
      );
      assign valid_vec[gi] = stage_q[gi][SW-1];
    end
  endgenerate

  // Tap mux: saturated select picks the input word or one of the stage outputs
  always_comb begin
    tap_next = stage_q[0];
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == sat_lat(int'(lat_sel), DEPTH)) begin
        tap_next = stage_q[k];
      end
    end
  end

  assign dout     = tap_next[WIDTH-1:0];
  assign dout_vld = tap_next[SW-1];
  assign busy     = |valid_vec;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (WIDTH=18, DEPTH=4): the driver pushes the
// expected tap/busy for each cycle from a queue-based history model, a separate
// monitor pops and compares against the live outputs.
module tb_pipe_stage_chain;

  localparam int WIDTH = 18;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ce = 1'b0;
  logic             flush = 1'b0;
  logic [LW-1:0]    lat_sel = '0;
  logic [WIDTH-1:0] din = '0;
  logic             din_vld = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             busy;

  pipe_stage_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .LW(LW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .flush   (flush),
    .lat_sel (lat_sel),
    .din     (din),
    .din_vld (din_vld),
    .dout    (dout),
    .dout_vld(dout_vld),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             v;
    logic             b;
    string            name;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: list of samples captured on enabled edges, newest first.
  // Anything beyond the list is a cleared stage (data 0, valid 0).
  logic [WIDTH:0] hist[$];

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  function automatic exp_t model_expect(input int lat, input string name);
    exp_t e;
    int   n;
    logic [WIDTH:0] w;
    n = (lat > DEPTH) ? DEPTH : lat;
    if (n == 0) w = {din_vld, din};
    else if (n - 1 < hist.size()) w = hist[n-1];
    else w = '0;
    e.d = w[WIDTH-1:0];
    e.v = w[WIDTH];
    e.b = 1'b0;
    foreach (hist[i]) if (hist[i][WIDTH]) e.b = 1'b1;
    e.name = name;
    return e;
  endfunction

  // One cycle: drive inputs mid-cycle, queue the expectation, then advance the model at the edge
  task automatic step(input bit c, input bit f, input bit r, input int l,
                      input logic [WIDTH-1:0] d, input bit v, input string name);
    bit c_h, f_h, r_h;
    @(negedge clk);
    ce = c; flush = f; rst = r; lat_sel = LW'(l); din = d; din_vld = v;
    if (r) hist.delete();
    exp_q.push_back(model_expect(l, name));
    c_h = c; f_h = f; r_h = r;
    @(posedge clk);
    if (!r_h) begin
      if (f_h) hist.delete();
      else if (c_h) begin
        hist.push_front({v, d});
        if (hist.size() > DEPTH) void'(hist.pop_back());
      end
    end
  endtask

  // Monitor: sample well after the inputs settle, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d %s lat=%0d din=%h/%b -> dout=%h vld=%b busy=%b", txn, e.name,
                 lat_sel, din, din_vld, dout, dout_vld, busy);
        checks++;
        if (dout !== e.d) begin
          failures++;
          $display("FAIL %s dout: got %h expected %h", e.name, dout, e.d);
        end
        checks++;
        if (dout_vld !== e.v) begin
          failures++;
          $display("FAIL %s dout_vld: got %b expected %b", e.name, dout_vld, e.v);
        end
        checks++;
        if (busy !== e.b) begin
          failures++;
          $display("FAIL %s busy: got %b expected %b", e.name, busy, e.b);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    // Reset state, observed on a registered tap
    step(1, 0, 1, 1, 18'h1234, 1, "reset");
    step(1, 0, 1, 4, 18'h0, 0, "reset");
    // Bypass while still in reset: output follows input
    step(1, 0, 1, 0, 18'h2AAAA, 1, "bypass_rst");
    step(1, 0, 0, 0, 18'h2AAAA, 1, "bypass");

    // Latency 3: single valid beat then zeros
    step(0, 1, 0, 3, 18'h0, 0, "clear");
    step(1, 0, 0, 3, 18'h00001, 1, "lat3");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 3, 18'h0, 0, "lat3");

    // Stall: stream 1,2 then ce low two cycles, then 3
    step(1, 0, 0, 2, 18'd1, 1, "stall");
    step(1, 0, 0, 2, 18'd2, 1, "stall");
    step(0, 0, 0, 2, 18'd9, 1, "stall");
    step(0, 0, 0, 2, 18'd9, 1, "stall");
    step(1, 0, 0, 2, 18'd3, 1, "stall");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 2, 18'd0, 0, "stall");

    // Flush priority: fill with all-ones, then flush together with ce
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 4, 18'h3FFFF, 1, "fill");
    step(1, 1, 0, 4, 18'h3FFFF, 1, "flush");
    step(1, 0, 0, 4, 18'h0, 0, "flushed");
    step(1, 0, 0, 1, 18'h0, 0, "flushed");

    // Async reset mid-stream, then release and resume capture
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2, 18'h100 + 18'(i), 1, "pre_rst");
    step(1, 0, 1, 2, 18'h155, 1, "async_rst");
    step(1, 0, 0, 1, 18'h0AB, 1, "release");
    step(1, 0, 0, 1, 18'h0CD, 1, "resume");
    step(1, 0, 0, 1, 18'h0, 0, "resume");

    // Saturation: same stream at lat_sel=7 and lat_sel=4
    for (int i = 0; i < 6; i++) step(1, 0, 0, 7, 18'h20 + 18'(i), 1, "sat7");
    for (int i = 0; i < 6; i++) step(1, 0, 0, 4, 18'h20 + 18'(i), 1, "sat4");

    // Mid-stream tap changes and random traffic
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 59) == 0, int'($urandom_range(0, 7)),
           WIDTH'($urandom), $urandom_range(0, 1) == 1, "rand");
    end

    // Let the monitor drain its queue, bounded
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      #4;
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
